// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared clock constants, ms->cycle helper and key FSM encodings.
package key_debounce_pkg;
  localparam int CLK_FREQ_HZ = 50_000_000;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, LONG_HELD = 2'd2} state_e;
  function automatic int ms_to_cyc(input int ms);
    return ms * (CLK_FREQ_HZ / 1000);
  endfunction
endpackage

// File: rtl/key_debounce_sync_2ff.sv
// key_debounce_sync_2ff: 1-bit two-flop synchroniser with a configurable reset level.
module key_debounce_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounces a raw key pin into a clean level plus press/release/long-press pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYC   = ms_to_cyc(20),
  parameter int LONG_CYC       = ms_to_cyc(1000)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int HW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC - 1);
  localparam logic REL_PIN = KEY_ACTIVE_LOW;
  logic pin_s, k_s, hit, press_ev, rel_ev;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic key_q, key_d, press_q, press_d, release_q, release_d, long_q, long_d;
  state_e fsm_q, fsm_d;
  key_debounce_sync_2ff #(.RST_VAL(REL_PIN)) u_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (key_in),
    .q_o    (pin_s)
  );
  // k_s is 1 while pressed regardless of pin polarity
  assign k_s      = pin_s ^ REL_PIN;
  assign hit      = (k_s != key_q) && (cnt_q == DB_MAX);
  assign press_ev = hit & ~key_q;
  assign rel_ev   = hit & key_q;
  assign cnt_d    = (k_s == key_q || hit) ? '0 : cnt_q + 1'b1;
  assign key_d    = key_q ^ hit;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      key_q     <= 1'b0;
      fsm_q     <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      fsm_q     <= fsm_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end
  always_comb begin
    fsm_d = IDLE;
    case (fsm_q)
      IDLE:      fsm_d = press_ev ? PRESSED : IDLE;
      PRESSED:   fsm_d = rel_ev ? IDLE : (hold_q == HOLD_MAX ? LONG_HELD : PRESSED);
      LONG_HELD: fsm_d = rel_ev ? IDLE : LONG_HELD;
      default:   fsm_d = IDLE;
    endcase
  end
  // hold clears on entry to PRESSED and freezes once LONG_HELD is reached
  always_comb begin
    hold_d    = (fsm_d == PRESSED) ? ((fsm_q == PRESSED) ? hold_q + 1'b1 : '0) : hold_q;
    press_d   = press_ev;
    release_d = rel_ev;
    long_d    = (fsm_q == PRESSED) && (fsm_d == LONG_HELD);
  end
  assign key_state   = key_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
endmodule
